uart_tx_cfg: RTL
================

Name: uart_tx_cfg

Overview:
- Next-generation UART transmitter: frame format (data bits, parity, stop bits) and baud divisor are configurable at runtime.
- Adds an internal TX FIFO with a valid/ready input handshake, so producers can queue bytes without polling clear-to-send.
- Sits between a byte source (CPU bus bridge, test pattern generator) and the off-chip serial TX pin.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, minimum 2.
- DIV_BITS, 16, width of runtime baud divisor input.

Ports:
- clock  input  1  system clock.
- i_rstn  input  1  reset: i_rstn, synchronous, active-low; clock: clock.
- i_data  input  8  byte to queue; only the low i_data_bits bits are sent.
- i_valid  input  1  push request.
- o_ready  output  1  FIFO not full; a push is accepted on a rising edge where i_valid && o_ready.
- i_divisor  input  DIV_BITS  bit period is i_divisor+1 cycles.
- i_data_bits  input  2  00=5, 01=6, 10=7, 11=8 data bits.
- i_parity  input  2  00=none, 01=even, 10=odd, 11=none (reserved).
- i_stop2  input  1  0=one stop bit, 1=two stop bits.
- o_serial  output  1  serial line; idle high; registered.
- o_busy  output  1  frame in progress, or FIFO not empty.
- o_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, including mid-frame: o_serial=1, o_ready=1, o_busy=0, o_count=0, state IDLE. The FIFO is flushed and any partial frame is abandoned. Outputs take these values after the first edge with i_rstn=0.
- FIFO:
  - o_ready = (count != FIFO_DEPTH), derived from registered count.
  - No push when full, even if a pop happens in the same cycle.
  - Simultaneous push and pop with count>0 leaves count unchanged.
  - No bypass: a push into an empty FIFO is popped no earlier than the next edge.
  - Pointers wrap modulo FIFO_DEPTH.
- Config latch: i_divisor, i_data_bits, i_parity and i_stop2 are captured at pop time and held for the whole frame. Changes mid-frame affect only the next frame.
- State machine, states IDLE, START, DATA, PARITY, STOP:
  - IDLE: if count>0, pop the head into the shift register, latch config, go to START. o_serial=0 from that edge on.
  - START: lasts one bit period, then DATA.
  - DATA: sends N bits, LSB first. Each bit lasts div+1 cycles. After bit N-1, go to PARITY if parity is enabled, else STOP.
  - PARITY: even parity bit = XOR of the N sent bits; odd parity bit = its inverse. Lasts one bit period.
  - STOP: o_serial=1 for 1 or 2 bit periods. On the last cycle of the last stop bit:
    - if count>0, pop and go directly to START (zero idle gap);
    - else go to IDLE.
- Bit timer: down-counter loaded with div at each bit start; the bit ends when it reaches 0. div=0 gives 1 cycle per bit (legal). The counter is DIV_BITS wide with no overflow.
- Bit counter: counts data bits 0..7; compared against N-1.
- Frame length: (1 + N + P + S) * (div+1) cycles, where P∈{0,1} and S∈{1,2}.
- Latency: push accepted at edge k → pop at edge k+1 → start bit visible after edge k+1 (2 cycles from i_valid sampled).
- o_busy = (state != IDLE) || (count != 0).
- Unused high data bits (N<8) are ignored and never transmitted.

Decomposition:
- Package uart_pkg:
  - parity_t enum (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD);
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - helper constant mapping i_data_bits code to bit count (5+code).
- One sub-module: sync_fifo (parameters WIDTH=8, DEPTH), with push/pop/full/empty/count outputs; reusable by a future uart_rx_cfg.
- The serializer FSM stays in uart_tx_cfg.

Test Plan:
- 8N1, div=3, push 0xA5 → o_serial low for cycles 0-3 after start, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. Total 40 cycles; o_busy drops after the stop bit.
- 7E2, div=0, push 0x53 → line shows 0, bits 1100101, parity 0 (four ones), then 1,1. Total 11 cycles; bit 7 of the data is never sent.
- 5O1, div=1, push 0x1F → 0, 11111, parity 0 (five ones, odd), 1. Total 16 cycles.
- Fill: hold i_valid with FIFO_DEPTH=8, div=0, 8N1 → o_ready falls once count=8. All 9 accepted bytes (8 queued plus 1 refilled after the first pop) go out back-to-back with no idle cycles between a stop bit and the next start bit.
- Change i_divisor from 3 to 1 mid-frame → current frame keeps 4 cycles/bit; the next frame uses 2 cycles/bit.
- Assert i_rstn=0 during the DATA state with 3 bytes queued → after the edge, o_serial=1, o_count=0, o_ready=1, o_busy=0. No further transitions until a new push.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART blocks.
package uart_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned BITCNT_W = 3;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Data-bit count for a frame-format code: 5 + code.
  function automatic logic [3:0] data_bits_n(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Byte-source handshake into the UART transmitter FIFO.
interface uart_tx_cfg_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;

  modport master (output i_data, output i_valid, input o_ready);
  modport slave  (input i_data, input i_valid, output o_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; no fall-through bypass.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     i_rstn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop frees a slot on the same edge.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines valid entries.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime frame format/baud and an input FIFO.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_BITS   = 16
) (
  input  logic                        clock,
  input  logic                        i_rstn,
  uart_tx_cfg_if.slave                tx_if,
  input  logic [DIV_BITS-1:0]         i_divisor,
  input  logic [1:0]                  i_data_bits,
  input  logic [1:0]                  i_parity,
  input  logic                        i_stop2,
  output logic                        o_serial,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

  tx_state_t             state_q, state_d;
  logic [DIV_BITS-1:0]   timer_q, timer_d;
  logic [DIV_BITS-1:0]   div_q, div_d;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [BITCNT_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  parity_t               par_q, par_d;
  logic                  stop2_q, stop2_d;
  logic                  stopcnt_q, stopcnt_d;
  logic                  parbit_q, parbit_d;
  logic                  serial_q, serial_d;

  logic                  pop_c;
  logic                  bit_end_c;
  logic                  par_en_c;
  logic                  full_c, empty_c;
  logic [DATA_W-1:0]     head_c;
  logic [$clog2(FIFO_DEPTH):0] count_c;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .i_rstn  (i_rstn),
    .push_i  (tx_if.i_valid),
    .wdata_i (tx_if.i_data),
    .pop_i   (pop_c),
    .rdata_o (head_c),
    .full_o  (full_c),
    .empty_o (empty_c),
    .count_o (count_c)
  );

  assign tx_if.o_ready = !full_c;
  assign o_serial      = serial_q;
  assign o_busy        = (state_q != IDLE) || !empty_c;
  assign o_count       = count_c;

  assign bit_end_c = (timer_q == '0);
  assign par_en_c  = (par_q == PAR_EVEN) || (par_q == PAR_ODD);

  // Next-state, line value and frame-config latch.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    div_d     = div_q;
    bitcnt_d  = bitcnt_q;
    last_d    = last_q;
    shift_d   = shift_q;
    par_d     = par_q;
    stop2_d   = stop2_q;
    stopcnt_d = stopcnt_q;
    parbit_d  = parbit_q;
    serial_d  = serial_q;
    pop_c     = 1'b0;

    if (state_q != IDLE) begin
      timer_d = bit_end_c ? div_q : (timer_q - DIV_BITS'(1));
    end

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        if (!empty_c) pop_c = 1'b1;
      end
      START: begin
        if (bit_end_c) begin
          state_d  = DATA;
          bitcnt_d = '0;
          serial_d = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end_c) begin
          parbit_d = parbit_q ^ shift_q[0];
          shift_d  = shift_q >> 1;
          if (bitcnt_q == last_q) begin
            if (par_en_c) begin
              state_d  = PARITY;
              serial_d = parbit_q ^ shift_q[0] ^ (par_q == PAR_ODD);
            end else begin
              state_d   = STOP;
              stopcnt_d = 1'b0;
              serial_d  = 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + BITCNT_W'(1);
            serial_d = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end_c) begin
          state_d   = STOP;
          stopcnt_d = 1'b0;
          serial_d  = 1'b1;
        end
      end
      STOP: begin
        serial_d = 1'b1;
        if (bit_end_c) begin
          if (stop2_q && !stopcnt_q) begin
            stopcnt_d = 1'b1;
          end else if (!empty_c) begin
            pop_c = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
      end
    endcase

    // Loading a new frame: the head byte and the config inputs of this cycle.
    if (pop_c) begin
      state_d   = START;
      shift_d   = head_c;
      div_d     = i_divisor;
      timer_d   = i_divisor;
      last_d    = BITCNT_W'(data_bits_n(i_data_bits) - 4'd1);
      par_d     = parity_t'(i_parity);
      stop2_d   = i_stop2;
      stopcnt_d = 1'b0;
      parbit_d  = 1'b0;
      serial_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!i_rstn) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      div_q     <= '0;
      bitcnt_q  <= '0;
      last_q    <= '0;
      shift_q   <= '0;
      par_q     <= PAR_NONE;
      stop2_q   <= 1'b0;
      stopcnt_q <= 1'b0;
      parbit_q  <= 1'b0;
      serial_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      div_q     <= div_d;
      bitcnt_q  <= bitcnt_d;
      last_q    <= last_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      stop2_q   <= stop2_d;
      stopcnt_q <= stopcnt_d;
      parbit_q  <= parbit_d;
      serial_q  <= serial_d;
    end
  end

endmodule
